fetch_seq_ctrl: RTL and testbench



---
 rtl/fetch_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: owns the PC, buffers fetched words in a small FIFO
// and hands them to decode over valid/ready. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_seq_ctrl #(
  parameter int          MEM_BYTES  = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] pc,
  input  logic [31:0] inst_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        done,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [7:0]  fetch_count
`endif
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HALT,
    S_ERR
  } state_t;

  state_t            state, state_next;
  logic [31:0]       pc_next;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [31:0]       fifo_pc   [FIFO_DEPTH];

  logic push, pop, flush, full, head_fire, redirect_legal, start_accept;

  assign full           = (count == FULL_CNT);
  assign inst_valid     = (count != '0);
  assign head_fire      = inst_valid && inst_ready;
  assign redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc < MEM_LIMIT);
  assign start_accept   = start && ((state == S_IDLE) || (state == S_HALT));

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = S_FETCH;
        end
      end
      S_FETCH, S_DRAIN: begin
        if (redirect_valid) begin
          // A redirect beats any push/pop this cycle; a bad target keeps pc for debug.
          flush = 1'b1;
          if (redirect_legal) begin
            pc_next    = redirect_pc;
            state_next = S_FETCH;
          end else begin
            state_next = S_ERR;
          end
        end else begin
          pop = head_fire;
          if (state == S_FETCH) begin
            push = !full || head_fire;
            if (push) begin
              if (pc == LAST_PC) state_next = S_DRAIN;
              else               pc_next    = pc + 32'd4;
            end
          end else if ((count == '0) || (pop && (count == CNT_W'(1)))) begin
            state_next = S_HALT;
          end
        end
      end
      S_ERR: begin
        flush = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array is not reset; occupancy is, and the outputs are
  // qualified by it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= inst_code;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

  assign inst_out = inst_valid ? fifo_data[rd_ptr] : 32'h0;
  assign inst_pc  = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign busy     = (state == S_FETCH) || (state == S_DRAIN);
  assign done     = (state == S_HALT);
  assign fault    = (state == S_ERR);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      stall_cycles <= '0;
      fetch_count  <= '0;
    end else begin
      if (inst_valid && !inst_ready && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (push)
        fetch_count <= fetch_count + 8'd1;
    end
  end
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: a vector table for control/boundary
// behaviour plus a scoreboard of expected {pc, word} pairs checked at each handshake.
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, inst_ready;
  logic [31:0] redirect_pc, pc, inst_code, inst_out, inst_pc;
  logic        inst_valid, busy, done, fault;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [7:0]  fetch_count;
`endif

  always #5 clk = ~clk;

  logic [31:0] mem [8] = '{32'h00940333, 32'h413903b3, 32'h00a4f2b3, 32'h40b50533,
                           32'h00c5c633, 32'h01bd5f33, 32'h00e6e733, 32'h00f768b3};
  assign inst_code = (pc < 32'd32) ? mem[pc[4:2]] : 32'hDEADBEEF;

  fetch_seq_ctrl dut (
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles   (stall_cycles),
    .fetch_count    (fetch_count),
`endif
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .pc             (pc),
    .inst_code      (inst_code),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        start;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic        e_fault;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
  } vec_t;

  exp_t sb_q [$];
  vec_t vecs [9];
  int   tests = 0;
  int   fails = 0;
  bit   last_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs set; compares any handshake, then advances one cycle.
  task automatic step();
    exp_t e;
    if (inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got inst_pc %h, expected no handshake", inst_pc);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", inst_pc, e.pc);
        check("sb_inst", inst_out, e.inst);
        if (sb_q.size() == 0) last_pop = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_run(input logic [31:0] from_pc);
    for (logic [31:0] a = from_pc; a < 32'd32; a += 32'd4)
      sb_q.push_back('{pc: a, inst: mem[a[4:2]]});
  endtask

  task automatic run_to_halt(input string name);
    last_pop   = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && !last_pop; i++) step();
    check({name, "_all_popped"}, 32'(last_pop), 32'd1);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pc_end"}, pc, 32'd28);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    //            start rv  rpc    valid busy done fault pc     ipc    inst
    vecs[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h00940333};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h00940333};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h00940333};
    vecs[5] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h00940333};
    vecs[6] = '{1'b0, 1'b1, 32'h6,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0};

    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc",    pc,       32'd0);
    check("rst_inst",  inst_out, 32'd0);
    check("rst_ipc",   inst_pc,  32'd0);

    // Startup latency, backpressure fill, ignored start, illegal 0x06 and ERR stickiness.
    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      inst_ready = 1'b0;
      step();
      start = 1'b0; redirect_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].e_done));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].e_fault));
      check($sformatf("vec%0d_pc", i),    pc, vecs[i].e_pc);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_ipc", i),  inst_pc,  vecs[i].e_ipc);
        check($sformatf("vec%0d_inst", i), inst_out, vecs[i].e_inst);
      end
    end
    do_reset();
    check("err_rst_fault", 32'(fault), 32'd0);
    check("err_rst_busy",  32'(busy),  32'd0);
    check("err_rst_pc",    pc, 32'd0);

    // Sequential fetch at full throughput, then restart from HALT.
    expect_run(32'h0);
    inst_ready = 1'b1;
    pulse_start();
    run_to_halt("seq");
    expect_run(32'h0);
    pulse_start();
    run_to_halt("restart");

    // Backpressure: five stalled cycles with a full FIFO, then release.
    do_reset();
    expect_run(32'h0);
    inst_ready = 1'b0;
    pulse_start();
    repeat (6) step();
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_pc",    pc, 32'd8);
    check("bp_ipc",   inst_pc, 32'd0);
    run_to_halt("bp");
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", 32'(stall_cycles), 32'd5);
    check("perf_fetch", 32'(fetch_count), 32'd8);
`endif

    // Redirect to 0x14 while FIFO holds pc 0 and 4.
    inst_ready = 1'b0;
    pulse_start();
    repeat (3) step();
    check("rd_pre_ipc", inst_pc, 32'd0);
    check("rd_pre_pc",  pc, 32'd8);
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    step();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(inst_valid), 32'd0);
    check("rd_pc",   pc, 32'h14);
    check("rd_busy", 32'(busy), 32'd1);
    expect_run(32'h14);
    run_to_halt("redir");

    // Illegal redirect to 0x20 (out of range).
    inst_ready = 1'b0;
    pulse_start();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    check("ill20_fault", 32'(fault), 32'd1);
    check("ill20_valid", 32'(inst_valid), 32'd0);
    check("ill20_pc",    pc, 32'd4);
    pulse_start();
    check("ill20_start_ign", 32'(fault), 32'd1);
    check("ill20_busy", 32'(busy), 32'd0);
    do_reset();
    check("ill20_rst_fault", 32'(fault), 32'd0);
    check("ill20_rst_done",  32'(done),  32'd0);

    // Reset mid-FETCH with two valid entries, then resume from 0.
    pulse_start();
    repeat (3) step();
    check("mid_pre_valid", 32'(inst_valid), 32'd1);
    do_reset();
    check("mid_valid", 32'(inst_valid), 32'd0);
    check("mid_pc",    pc, 32'd0);
    check("mid_busy",  32'(busy), 32'd0);
    expect_run(32'h0);
    pulse_start();
    run_to_halt("mid_resume");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
